// File: rtl/jtbubl_video_pkg.sv
// jtbubl_video_pkg
// Shared definitions for the jtbubl video timing block:
//   - default Bubble Bobble screen geometry (H/V extents, blank and sync positions)
//   - default system-clock-to-pixel divider ratio and blank delay depth
//   - offset_t: signed 4-bit sync offset used by the optional sync-shift feature
//   - wrap_pos(): folds a shifted position back into an inclusive lo..hi range
package jtbubl_video_pkg;

  localparam int BUBL_CEN_DIV  = 8;    // 48 MHz / 8 = 6 MHz pixel clock
  localparam int BUBL_H_LAST   = 383;
  localparam int BUBL_HB_START = 256;
  localparam int BUBL_HB_END   = 0;
  localparam int BUBL_HS_START = 300;
  localparam int BUBL_HS_END   = 332;
  localparam int BUBL_V_START  = 16;
  localparam int BUBL_V_LAST   = 279;
  localparam int BUBL_VB_START = 240;
  localparam int BUBL_VB_END   = 16;
  localparam int BUBL_VS_START = 250;
  localparam int BUBL_VS_END   = 253;
  localparam int BUBL_DLY      = 2;

  typedef logic signed [3:0] offset_t;

  // Offsets are at most +/-8, so a single fold is enough.
  function automatic int wrap_pos(input int pos, input int lo, input int hi);
    int span;
    span = hi - lo + 1;
    if (pos < lo) return pos + span;
    if (pos > hi) return pos - span;
    return pos;
  endfunction

endpackage

// File: rtl/jtbubl_cen_div.sv
// jtbubl_cen_div
// Divides the system clock into registered one-clk-wide pixel enables.
// Ports:
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   pxl_cen  out pixel enable, once every CEN_DIV clocks
//   pxl2_cen out double-pixel enable, twice every CEN_DIV clocks (shares pxl_cen's slot)
module jtbubl_cen_div
  import jtbubl_video_pkg::*;
#(
  parameter int CEN_DIV = BUBL_CEN_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic pxl_cen,
  output logic pxl2_cen
);

  localparam int CW = (CEN_DIV > 2) ? $clog2(CEN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CEN_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CEN_DIV / 2 - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pxl_cen_q, pxl2_cen_q;

  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  // Enables are registered from the current count, so the first pxl_cen
  // appears CEN_DIV clocks after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      pxl_cen_q  <= 1'b0;
      pxl2_cen_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pxl_cen_q  <= (cnt_q == CNT_LAST);
      pxl2_cen_q <= (cnt_q == CNT_LAST) || (cnt_q == CNT_HALF);
    end
  end

  assign pxl_cen  = pxl_cen_q;
  assign pxl2_cen = pxl2_cen_q;

endmodule

// File: rtl/jtbubl_vtiming.sv
// jtbubl_vtiming
// Parametrised video timing generator: pixel enables, H/V counters, blanking,
// sync, render lookahead and pipeline-delayed blanking.
// Optional feature macro: JTBUBL_VTIMER_SHIFT_EN adds signed sync offsets
// hoffset/voffset (sampled at vinit) that move HS/VS without touching blanking.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   hoffset, voffset    (JTBUBL_VTIMER_SHIFT_EN only) signed HS/VS offsets
//   pxl2_cen, pxl_cen   double-pixel / pixel clock enables
//   hdump, vdump        current pixel position
//   vrender             next line number (wraps V_LAST -> V_START)
//   hinit, vinit        line-start / frame-start strobes (one pxl_cen wide)
//   LHBL, LVBL          active-low blanking
//   LHBL_dly, LVBL_dly  blanking delayed DLY pixels
//   HS, VS              active-high syncs
//   frame               toggles every frame
module jtbubl_vtiming
  import jtbubl_video_pkg::*;
#(
  parameter int CEN_DIV  = BUBL_CEN_DIV,
  parameter int HW       = 9,
  parameter int VW       = 9,
  parameter int H_LAST   = BUBL_H_LAST,
  parameter int HB_START = BUBL_HB_START,
  parameter int HB_END   = BUBL_HB_END,
  parameter int HS_START = BUBL_HS_START,
  parameter int HS_END   = BUBL_HS_END,
  parameter int V_START  = BUBL_V_START,
  parameter int V_LAST   = BUBL_V_LAST,
  parameter int VB_START = BUBL_VB_START,
  parameter int VB_END   = BUBL_VB_END,
  parameter int VS_START = BUBL_VS_START,
  parameter int VS_END   = BUBL_VS_END,
  parameter int DLY      = BUBL_DLY
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef JTBUBL_VTIMER_SHIFT_EN
  input  offset_t       hoffset,
  input  offset_t       voffset,
`endif
  output logic          pxl2_cen,
  output logic          pxl_cen,
  output logic [HW-1:0] hdump,
  output logic [VW-1:0] vdump,
  output logic [VW-1:0] vrender,
  output logic          hinit,
  output logic          vinit,
  output logic          LHBL,
  output logic          LVBL,
  output logic          LHBL_dly,
  output logic          LVBL_dly,
  output logic          HS,
  output logic          VS,
  output logic          frame
);

  // Parameter legality
  if ((CEN_DIV % 2) != 0 || CEN_DIV < 2) begin : g_bad_cen_div
    $error("jtbubl_vtiming: CEN_DIV must be even and >= 2");
  end
  if (H_LAST >= 2**HW) begin : g_bad_hw
    $error("jtbubl_vtiming: H_LAST does not fit in HW bits");
  end
  if (V_LAST >= 2**VW) begin : g_bad_vw
    $error("jtbubl_vtiming: V_LAST does not fit in VW bits");
  end

  localparam logic [HW-1:0] H_LAST_L   = HW'(H_LAST);
  localparam logic [HW-1:0] HB_START_L = HW'(HB_START);
  localparam logic [HW-1:0] HB_END_L   = HW'(HB_END);
  localparam logic [VW-1:0] V_START_L  = VW'(V_START);
  localparam logic [VW-1:0] V_LAST_L   = VW'(V_LAST);
  localparam logic [VW-1:0] VB_START_L = VW'(VB_START);
  localparam logic [VW-1:0] VB_END_L   = VW'(VB_END);
  localparam logic [VW-1:0] VREND_RST  = VW'(V_START + 1);

  logic [HW-1:0] hdump_q, hdump_d;
  logic [VW-1:0] vdump_q, vdump_d;
  logic [VW-1:0] vrender_q, vrender_d;
  logic          frame_q, frame_d;
  logic          lhbl_q, lhbl_d;
  logic          lvbl_q, lvbl_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          h_wrap, v_wrap;

  logic [HW-1:0] hs_start_pos, hs_end_pos;
  logic [VW-1:0] vs_start_pos, vs_end_pos;

  jtbubl_cen_div #(
    .CEN_DIV (CEN_DIV)
  ) u_cen_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .pxl_cen  (pxl_cen),
    .pxl2_cen (pxl2_cen)
  );

  assign h_wrap = (hdump_q == H_LAST_L);
  assign v_wrap = (vdump_q == V_LAST_L);
  assign hinit  = pxl_cen & h_wrap;
  assign vinit  = hinit & v_wrap;

`ifdef JTBUBL_VTIMER_SHIFT_EN
  offset_t hoff_q, voff_q;

  // Offsets only change at a frame boundary so a frame never sees a torn sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hoff_q <= '0;
      voff_q <= '0;
    end else if (vinit) begin
      hoff_q <= hoffset;
      voff_q <= voffset;
    end
  end

  always_comb begin
    hs_start_pos = HW'(wrap_pos(HS_START + int'(hoff_q), 0, H_LAST));
    hs_end_pos   = HW'(wrap_pos(HS_END   + int'(hoff_q), 0, H_LAST));
    vs_start_pos = VW'(wrap_pos(VS_START + int'(voff_q), V_START, V_LAST));
    vs_end_pos   = VW'(wrap_pos(VS_END   + int'(voff_q), V_START, V_LAST));
  end
`else
  assign hs_start_pos = HW'(HS_START);
  assign hs_end_pos   = HW'(HS_END);
  assign vs_start_pos = VW'(VS_START);
  assign vs_end_pos   = VW'(VS_END);
`endif

  // Next-state values; flags are evaluated against the new count so that
  // they line up with the hdump/vdump they describe.
  always_comb begin
    hdump_d   = h_wrap ? '0 : hdump_q + 1'b1;
    vdump_d   = vdump_q;
    vrender_d = vrender_q;
    frame_d   = frame_q;
    if (h_wrap) begin
      vdump_d   = v_wrap ? V_START_L : vdump_q + 1'b1;
      vrender_d = (vdump_d == V_LAST_L) ? V_START_L : vdump_d + 1'b1;
      if (v_wrap) frame_d = ~frame_q;
    end

    lhbl_d = lhbl_q;
    if (HB_START != HB_END) begin
      if (hdump_d == HB_END_L)        lhbl_d = 1'b1;
      else if (hdump_d == HB_START_L) lhbl_d = 1'b0;
    end

    hs_d = hs_q;
    if (HS_START != HS_END) begin
      if (hdump_d == hs_start_pos)    hs_d = 1'b1;
      else if (hdump_d == hs_end_pos) hs_d = 1'b0;
    end

    lvbl_d = lvbl_q;
    if (VB_START != VB_END && h_wrap) begin
      if (vdump_d == VB_END_L)        lvbl_d = 1'b1;
      else if (vdump_d == VB_START_L) lvbl_d = 1'b0;
    end

    // VS edges are tied to the HS rising position of the chosen lines.
    vs_d = vs_q;
    if (VS_START != VS_END && hdump_d == hs_start_pos) begin
      if (vdump_q == vs_start_pos)    vs_d = 1'b1;
      else if (vdump_q == vs_end_pos) vs_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdump_q   <= '0;
      vdump_q   <= V_START_L;
      vrender_q <= VREND_RST;
      frame_q   <= 1'b0;
      lhbl_q    <= 1'b0;
      lvbl_q    <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
    end else if (pxl_cen) begin
      hdump_q   <= hdump_d;
      vdump_q   <= vdump_d;
      vrender_q <= vrender_d;
      frame_q   <= frame_d;
      lhbl_q    <= lhbl_d;
      lvbl_q    <= lvbl_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
    end
  end

  // Blanking delay line matching the gfx/colmix pipeline depth.
  if (DLY > 0) begin : g_dly
    logic [DLY-1:0] lhbl_pipe_q, lvbl_pipe_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lhbl_pipe_q <= '0;
        lvbl_pipe_q <= '0;
      end else if (pxl_cen) begin
        for (int i = DLY - 1; i > 0; i--) begin
          lhbl_pipe_q[i] <= lhbl_pipe_q[i-1];
          lvbl_pipe_q[i] <= lvbl_pipe_q[i-1];
        end
        lhbl_pipe_q[0] <= lhbl_q;
        lvbl_pipe_q[0] <= lvbl_q;
      end
    end

    assign LHBL_dly = lhbl_pipe_q[DLY-1];
    assign LVBL_dly = lvbl_pipe_q[DLY-1];
  end else begin : g_nodly
    assign LHBL_dly = lhbl_q;
    assign LVBL_dly = lvbl_q;
  end

  assign hdump   = hdump_q;
  assign vdump   = vdump_q;
  assign vrender = vrender_q;
  assign frame   = frame_q;
  assign LHBL    = lhbl_q;
  assign LVBL    = lvbl_q;
  assign HS      = hs_q;
  assign VS      = vs_q;

endmodule

// File: doc/jtbubl_vtiming.md
Name: jtbubl_vtiming

Overview:
- Parametrised video timing generator for the jtbubl video subsystem, replacing the fixed clock-enable divider plus fixed-geometry timer pair.
- Derives pixel clock enables from the system clock and runs the H/V counters.
- Produces blanking, sync and render-lookahead signals, plus blanking copies delayed to match the gfx/colmix pipeline.
- Geometry, divider ratio and blank delay are parameters, so other boards in the family reuse the block unchanged.

Parameters:
CEN_DIV, 8, system clocks per pixel; even, >=2 (48 MHz/8 = 6 MHz)
HW, 9, width of hdump
VW, 9, width of vdump/vrender
H_LAST, 383, last H count; H runs 0..H_LAST
HB_START, 256, hdump value at which LHBL falls
HB_END, 0, hdump value at which LHBL rises
HS_START, 300, hdump value at which HS rises
HS_END, 332, hdump value at which HS falls
V_START, 16, first V count
V_LAST, 279, last V count; V runs V_START..V_LAST
VB_START, 240, vdump value at which LVBL falls
VB_END, 16, vdump value at which LVBL rises
VS_START, 250, vdump value at which VS rises
VS_END, 253, vdump value at which VS falls
DLY, 2, pxl_cen ticks of delay for LHBL_dly/LVBL_dly; 0 = no delay

Ports:
clk       in   1   system clock (48 MHz), sole clock
rst_n     in   1   asynchronous active-low reset
pxl2_cen  out  1   double-pixel clock enable
pxl_cen   out  1   pixel clock enable
hdump     out  HW  horizontal position
vdump     out  VW  vertical position
vrender   out  VW  next line (vdump+1 with wrap)
hinit     out  1   line-start strobe
vinit     out  1   frame-start strobe
LHBL      out  1   active-low horizontal blank
LVBL      out  1   active-low vertical blank
LHBL_dly  out  1   LHBL delayed DLY pixels
LVBL_dly  out  1   LVBL delayed DLY pixels
HS        out  1   horizontal sync, active high
VS        out  1   vertical sync, active high
frame     out  1   toggles every frame

Behaviour:
- Reset (asynchronous, rst_n=0):
  - divider count=0; hdump=0; vdump=V_START; vrender=V_START+1; frame=0.
  - All strobes, blanks, syncs and delay-pipe stages = 0.
- Clock enables:
  - Divider counts 0..CEN_DIV-1.
  - pxl_cen=1 when count==CEN_DIV-1.
  - pxl2_cen=1 when count==CEN_DIV/2-1 or CEN_DIV-1.
  - Both are registered, 1 clk wide; first pxl_cen is CEN_DIV clk after reset release.
- Counters and strobes (state advances only on pxl_cen):
  - hdump increments; H_LAST wraps to 0.
  - On that wrap, vdump increments; V_LAST wraps to V_START and frame toggles.
  - vrender is always vdump+1, with V_LAST+1 mapped to V_START; updated together with vdump.
  - hinit = pxl_cen & hdump==H_LAST.
  - vinit = hinit & vdump==V_LAST.
- Edge-based flags (registered, updated on the same pxl_cen as the counters, aligned to the new count):
  - LHBL cleared when next hdump==HB_START, set when next hdump==HB_END.
  - HS set at HS_START, cleared at HS_END.
  - LVBL cleared when next vdump==VB_START, set when next vdump==VB_END; evaluated only at the H wrap.
  - VS set when vdump==VS_START and next hdump==HS_START; cleared when vdump==VS_END and next hdump==HS_START. VS edges therefore coincide with HS rising.
  - Start==end: the flag never changes from its reset value.
- Start-up and reset mid-operation:
  - After reset, LHBL/LVBL stay 0 until their first rising edge, so the first partial frame is blanked; timing is valid from the first vinit.
  - Reset mid-line or mid-frame abandons the frame immediately; no partial pulse completes.
- Blank delay:
  - LHBL_dly/LVBL_dly come from a DLY-deep shift register that advances on pxl_cen.
  - DLY=0: they are wired to LHBL/LVBL.
- Widths: counters must hold H_LAST and V_LAST+1. Parameter legality is checked at elaboration (CEN_DIV odd, or V_LAST >= 2**VW, raises $error).

Optional Feature:
- Macro: JTBUBL_VTIMER_SHIFT_EN.
- Defined:
  - Adds inputs hoffset[3:0] and voffset[3:0], both signed, sampled at vinit.
  - HS edge positions become HS_START+hoffset and HS_END+hoffset, modulo H_LAST+1.
  - VS line positions become VS_START+voffset and VS_END+voffset, wrapped within V_START..V_LAST.
  - Blanking is unaffected.
- Undefined: ports absent; offsets are fixed at 0; logic is removed.

Decomposition:
- Package jtbubl_video_pkg:
  - default Bubble Bobble geometry constants (H_LAST, V_START, V_LAST, blank and sync positions);
  - CEN_DIV default;
  - the typedef for signed 4-bit offsets.
- One sub-module, jtbubl_cen_div: divider producing pxl_cen and pxl2_cen, parameter CEN_DIV.

Test Plan:
- Reset release, CEN_DIV=8 -> pxl_cen every 8 clk with first at clk 8; pxl2_cen every 4 clk; pxl_cen and pxl2_cen coincide.
- Run one line -> hdump 0..383 then 0; LHBL falls at hdump=256 and rises at 0 (256 active pixels); HS high for hdump 300..331 (32 pixels); one hinit per line.
- Run two frames -> vdump 16..279 then 16 (264 lines, about 59.19 Hz); LVBL low for vdump 240..279 (224 active lines); VS high 3 lines starting at the HS rise on line 250; frame toggles at each vinit.
- DLY=2 -> LHBL_dly edges exactly 2 pxl_cen after LHBL edges; DLY=0 -> LHBL_dly identical to LHBL.
- rst_n low asynchronously at hdump=100, vdump=120 -> all outputs at reset values within the same clk; after release the counters restart at 0/16 and LVBL stays 0 until vdump returns to 16.
- JTBUBL_VTIMER_SHIFT_EN, hoffset=-4, voffset=+2 -> after next vinit, HS high 296..327 and VS rises on line 252; LHBL/LVBL unchanged.
